// File: rtl/lsu_rmw.sv
// Load/store unit bridging the CPU datapath to a single-port, word-wide,
// little-endian data memory. Sub-word stores are done as read-modify-write;
// sub-word loads are sign- or zero-extended.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (reject misaligned half/word).
module lsu_rmw #(
    parameter int ADDR_W = 32
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_rw,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [1:0]  lo_q;
    logic [15:0] wdata_q;

    // Select the addressed lane of a memory word and extend it.
    function automatic logic [31:0] extract(input logic [31:0] word,
                                            input logic [1:0]  lo,
                                            input logic [1:0]  sz,
                                            input logic        sx);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        if (sz[1])
            extract = word;
        else if (sz[0])
            extract = {{16{sx & h[15]}}, h};
        else
            extract = {{24{sx & b[7]}}, b};
    endfunction

    // Replace only the addressed lane(s) of the old word with store data.
    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [15:0] nd,
                                          input logic [1:0]  lo,
                                          input logic        half);
        logic [31:0] r;
        r = old;
        if (half) begin
            if (lo[1]) r[31:16] = nd;
            else       r[15:0]  = nd;
        end else begin
            case (lo)
                2'd0:    r[7:0]   = nd[7:0];
                2'd1:    r[15:8]  = nd[7:0];
                2'd2:    r[23:16] = nd[7:0];
                default: r[31:24] = nd[7:0];
            endcase
        end
        merge = r;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [1:0] sz,
                                           input logic [1:0] lo);
        if (sz[1])      is_misaligned = (lo != 2'd0);
        else if (sz[0]) is_misaligned = lo[0];
        else            is_misaligned = 1'b0;
    endfunction
`else
    assign misalign = 1'b0;
`endif

    // Request sequencer: all handshake and memory-side outputs are registered.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            size_q    <= 2'd0;
            sign_q    <= 1'b0;
            lo_q      <= 2'd0;
            wdata_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rw    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q     <= we;
                        size_q   <= size;
                        sign_q   <= sign_ext;
                        lo_q     <= addr[1:0];
                        wdata_q  <= wdata[15:0];
                        busy     <= 1'b1;
                        mem_addr <= {addr[ADDR_W-1:2], 2'b00};
`ifdef LSU_MISALIGN_TRAP_EN
                        if (is_misaligned(size, addr[1:0])) begin
                            misalign <= 1'b1;
                            done     <= 1'b1;
                            state    <= RESP;
                        end else
`endif
                        if (we && size[1]) begin
                            mem_wdata <= wdata;
                            mem_rw    <= 1'b1;
                            state     <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    if (we_q) begin
                        mem_wdata <= merge(mem_rdata, wdata_q, lo_q, size_q[0]);
                        mem_rw    <= 1'b1;
                        state     <= WR;
                    end else begin
                        rdata <= extract(mem_rdata, lo_q, size_q, sign_q);
                        done  <= 1'b1;
                        state <= RESP;
                    end
                end
                WR: begin
                    mem_rw <= 1'b0;
                    done   <= 1'b1;
                    state  <= RESP;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    misalign <= 1'b0;
`endif
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// Self-checking bench for lsu_rmw: a word memory model answers the DUT, a
// byte-array reference model predicts load results and memory contents.
module tb_lsu_rmw;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'd0;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, misalign, mem_rw;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] ram  [0:63];
    logic [7:0]  refb [0:255];
    logic [31:0] last_rdata = '0;
    logic [31:0] last_wd = '0;
    int unsigned wr_cnt = 0;
    int unsigned errors = 0;
    int unsigned checks = 0;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    lsu_rmw #(.ADDR_W(32)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .req(req), .we(we), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy),
        .done(done), .rdata(rdata), .misalign(misalign), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_rdata(mem_rdata)
    );

    always #5 Clock = ~Clock;

    assign mem_rdata = ram[mem_addr[7:2]];

    always @(posedge Clock) if (mem_rw) ram[mem_addr[7:2]] <= mem_wdata;

    always @(negedge Clock) if (mem_rw) begin
        wr_cnt  = wr_cnt + 1;
        last_wd = mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int unsigned idx, input logic [31:0] v);
        ram[idx] = v;
        for (int unsigned i = 0; i < 4; i++) refb[idx*4+i] = v[8*i +: 8];
    endtask

    function automatic logic [31:0] ref_word(input int unsigned idx);
        logic [31:0] v;
        v = '0;
        for (int unsigned i = 0; i < 4; i++) v |= 32'(refb[idx*4+i]) << (8*i);
        return v;
    endfunction

    function automatic int unsigned nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [7:0] a, input logic [1:0] sz, input logic sx);
        int unsigned n, base;
        logic [31:0] v;
        n = nbytes(sz);
        base = int'(a) - (int'(a) % n);
        v = '0;
        for (int unsigned i = 0; i < n; i++) v |= 32'(refb[base+i]) << (8*i);
        if (sx && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8*n);
        return v;
    endfunction

    task automatic ref_store(input logic [7:0] a, input logic [1:0] sz, input logic [31:0] d);
        int unsigned n, base;
        n = nbytes(sz);
        base = int'(a) - (int'(a) % n);
        for (int unsigned i = 0; i < n; i++) refb[base+i] = d[8*i +: 8];
    endtask

    // One request through the handshake, checked against the reference model.
    task automatic run_op(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [7:0] a, input logic [31:0] wd, input bit hold_req);
        bit mis;
        int unsigned n, exp_lat, lat;
        logic first_rw;
        logic [31:0] first_addr;
        n = nbytes(sz);
        mis = TRAP && ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'd0));
        exp_lat = mis ? 1 : (!w || n == 4) ? 2 : 3;
        if (!mis && !w) last_rdata = ref_load(a, sz, sx);
        if (!mis && w) ref_store(a, sz, wd);
        @(negedge Clock);
        wr_cnt = 0;
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = {24'd0, a}; wdata = wd;
        @(posedge Clock); #1;
        if (!hold_req) req = 1'b0;
        first_rw = mem_rw;
        first_addr = mem_addr;
        lat = 1;
        while (!done && lat <= 8) begin
            @(posedge Clock); #1;
            lat++;
        end
        req = 1'b0;
        chk("latency", lat, exp_lat);
        chk("misalign", {31'd0, misalign}, {31'd0, mis});
        chk("rdata", rdata, last_rdata);
        chk("first_rw", {31'd0, first_rw}, {31'd0, (!mis && w && n == 4)});
        if (!mis) chk("mem_addr", first_addr, {24'd0, a[7:2], 2'b00});
        @(posedge Clock); #1;
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("wr_cycles", wr_cnt, (!mis && w) ? 1 : 0);
    endtask

    initial begin
        for (int unsigned i = 0; i < 64; i++) set_word(i, i * i);
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_rw", {31'd0, mem_rw}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge Clock); Reset_n = 1'b1;

        run_op(1'b0, 2'd2, 1'b0, 8'h14, 32'd0, 1'b0);
        chk("word_load_0x14", rdata, 32'h0000_0019);

        set_word(2, 32'h0000_80FF);
        run_op(1'b0, 2'd0, 1'b1, 8'h08, 32'd0, 1'b0);
        chk("byte_sx", rdata, 32'hFFFF_FFFF);
        run_op(1'b0, 2'd0, 1'b0, 8'h08, 32'd0, 1'b0);
        chk("byte_zx", rdata, 32'h0000_00FF);
        run_op(1'b0, 2'd1, 1'b1, 8'h08, 32'd0, 1'b0);
        chk("half_sx", rdata, 32'hFFFF_80FF);

        set_word(3, 32'h1122_3344);
        run_op(1'b1, 2'd0, 1'b0, 8'h0E, 32'h0000_00AB, 1'b0);
        chk("rmw_wdata", last_wd, 32'h11AB_3344);
        run_op(1'b0, 2'd2, 1'b0, 8'h0C, 32'd0, 1'b0);
        chk("rmw_readback", rdata, 32'h11AB_3344);

        // req held high through the whole transaction must not start a second one
        run_op(1'b1, 2'd2, 1'b0, 8'h04, 32'hDEAD_BEEF, 1'b1);
        chk("word_store_ram", ram[1], 32'hDEAD_BEEF);

        run_op(1'b1, 2'd2, 1'b0, 8'h06, 32'hCAFE_F00D, 1'b0);
        chk("unaligned_word_store", ram[1], ref_word(1));

        for (int unsigned k = 0; k < 48; k++)
            run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   8'($urandom_range(0, 255)), $urandom, 1'b0);

        // Reset during the read half of a byte store: no write, no done
        @(negedge Clock);
        wr_cnt = 0;
        req = 1'b1; we = 1'b1; size = 2'd0; addr = 32'h21; wdata = 32'h55;
        @(posedge Clock); #1;
        req = 1'b0;
        chk("rmw_rd_busy", {31'd0, busy}, 32'd1);
        Reset_n = 1'b0; #1;
        chk("abort_mem_rw", {31'd0, mem_rw}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge Clock);
        #1;
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_writes", wr_cnt, 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        last_rdata = '0;
        @(negedge Clock); Reset_n = 1'b1;
        chk("abort_ram", ram[8], ref_word(8));

        run_op(1'b0, 2'd1, 1'b0, 8'h22, 32'd0, 1'b0);

        for (int unsigned i = 0; i < 64; i++) chk("final_ram", ram[i], ref_word(i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
